reset_source: RTL and testbench

RESET_SOURCE -- requirements
Module: reset_source

---
 rtl/reset_source.sv | 119 +++++++++++
 tb/tb_reset_source.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_source.sv
// Reset request generator: debounced reset button, software reboot and power-on
// pulse, each producing one fixed-width async_res pulse followed by a hold-off window.
module reset_source #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter logic [15:0] PULSE_CYCLES    = 16'd4,
    parameter logic [15:0] HOLDOFF_CYCLES  = 16'd16
) (
    input  logic       clock,
    input  logic       resn,
    input  logic       button_n,
    input  logic       sw_reboot,
    output logic       async_res,
    output logic [1:0] cause,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SW     = 2'b10;

    logic        btn_sync_p0;
    logic        button_s;
    logic        btn_db;
    logic        btn_db_p1;
    logic [15:0] db_cnt;
    logic        btn_trig;
    state_t      state;
    logic [15:0] cnt;

    // Stage p0: two-flop synchroniser for the asynchronous button pin
    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            btn_sync_p0 <= 1'b1;
            button_s    <= 1'b1;
        end else begin
            btn_sync_p0 <= button_n;
            button_s    <= btn_sync_p0;
        end
    end

    // Stage p1: debounce, then remember the previous debounced level for edge detection
    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            btn_db    <= 1'b1;
            btn_db_p1 <= 1'b1;
            db_cnt    <= '0;
        end else begin
            btn_db_p1 <= btn_db;
            if (button_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt + 16'd1 == DEBOUNCE_CYCLES) begin
                btn_db <= button_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    // Only a debounced press counts; a release or a held-low level never triggers.
    assign btn_trig = btn_db_p1 & ~btn_db;

    // Stage p2: pulse / hold-off sequencer; reset lands in PULSE to form the power-on pulse
    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            state     <= PULSE;
            cnt       <= PULSE_CYCLES;
            async_res <= 1'b1;
            cause     <= CAUSE_POR;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_trig || sw_reboot) begin
                        state     <= PULSE;
                        cnt       <= PULSE_CYCLES;
                        async_res <= 1'b1;
                        busy      <= 1'b1;
                        cause     <= btn_trig ? CAUSE_BUTTON : CAUSE_SW;
                    end
                end
                PULSE: begin
                    if (cnt == 16'd1) begin
                        async_res <= 1'b0;
                        if (HOLDOFF_CYCLES == 16'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= HOLDOFF;
                            cnt   <= HOLDOFF_CYCLES;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == 16'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    async_res <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_source.sv
// Self-checking bench for reset_source: directed vector table, hand-written
// corner sequences and randomized stimulus against a busy-time reference model.
module tb_reset_source;

    localparam logic [15:0] D = 16'd4;
    localparam logic [15:0] P = 16'd3;
    localparam logic [15:0] H = 16'd5;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       resn, button_n, sw_reboot, async_res, busy;
    logic [1:0] cause;
    logic       resn_h, button_h, sw_h, async_res_h, busy_h;
    logic [1:0] cause_h;

    reset_source #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) u_dut (
        .clock(clock), .resn(resn), .button_n(button_n), .sw_reboot(sw_reboot),
        .async_res(async_res), .cause(cause), .busy(busy)
    );

    reset_source #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(16'd0)) u_dut_h0 (
        .clock(clock), .resn(resn_h), .button_n(button_h), .sw_reboot(sw_h),
        .async_res(async_res_h), .cause(cause_h), .busy(busy_h)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: busy time remaining after a trigger is PULSE+HOLDOFF,
    // async_res is high while more than HOLDOFF cycles remain.
    int         m_rem, m_run;
    logic       m_s0, m_s1, m_db, m_fall;
    logic [1:0] m_cause;

    function void model_reset();
        m_rem   = int'(P) + int'(H);
        m_cause = 2'b00;
        m_s0    = 1'b1;
        m_s1    = 1'b1;
        m_db    = 1'b1;
        m_run   = 0;
        m_fall  = 1'b0;
    endfunction

    function void model_step();
        logic trig_b;
        trig_b = m_fall;
        if (m_rem == 0 && (trig_b || sw_reboot)) begin
            m_rem   = int'(P) + int'(H);
            m_cause = trig_b ? 2'b01 : 2'b10;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        m_fall = 1'b0;
        if (m_s1 != m_db) begin
            m_run++;
            if (m_run == int'(D)) begin
                m_db   = m_s1;
                m_run  = 0;
                m_fall = !m_s1;
            end
        end else begin
            m_run = 0;
        end
        m_s1 = m_s0;
        m_s0 = button_n;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (!resn) model_reset();
        else model_step();
        @(negedge clock);
        check("model_async_res", int'(async_res), int'(m_rem > int'(H)));
        check("model_busy", int'(busy), int'(m_rem > 0));
        check("model_cause", int'(cause), int'(m_cause));
    endtask

    typedef struct {
        logic       resn;
        logic       sw;
        logic       ar;
        logic [1:0] cause;
        logic       busy;
        logic       busy_h;
    } vec_t;

    vec_t tbl[18];

    function void set_row(input int i, input logic r, input logic s, input logic a,
                          input logic [1:0] c, input logic b, input logic bh);
        tbl[i].resn = r; tbl[i].sw = s; tbl[i].ar = a;
        tbl[i].cause = c; tbl[i].busy = b; tbl[i].busy_h = bh;
    endfunction

    initial begin
        int lat, highs;
        bit found;

        // Power-on, software reboot and a software request ignored in hold-off
        set_row(0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        set_row(1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        set_row(2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        for (int i = 3; i <= 7; i++) set_row(i, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        set_row(8, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        set_row(9, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        set_row(10, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        set_row(11, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        set_row(12, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        set_row(13, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        for (int i = 14; i <= 16; i++) set_row(i, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        set_row(17, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);

        resn = 1'b0; resn_h = 1'b0;
        button_n = 1'b1; button_h = 1'b1;
        sw_reboot = 1'b0; sw_h = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_async_res", int'(async_res), 1);
        check("reset_cause", int'(cause), 0);
        check("reset_busy", int'(busy), 1);

        for (int i = 0; i < 18; i++) begin
            resn      = tbl[i].resn;
            resn_h    = tbl[i].resn;
            sw_reboot = tbl[i].sw;
            tick();
            check($sformatf("table%0d_async_res", i), int'(async_res), int'(tbl[i].ar));
            check($sformatf("table%0d_cause", i), int'(cause), int'(tbl[i].cause));
            check($sformatf("table%0d_busy", i), int'(busy), int'(tbl[i].busy));
            check($sformatf("table%0d_busy_h0", i), int'(busy_h), int'(tbl[i].busy_h));
        end
        sw_reboot = 1'b0;

        // Clean press: latency, width, cause, then no re-trigger while held
        button_n = 1'b0;
        lat = 0; found = 1'b0;
        for (int k = 1; k <= 40 && !found; k++) begin
            tick();
            if (async_res) begin lat = k; found = 1'b1; end
        end
        check("press_latency", lat, 7);
        check("press_cause", int'(cause), 1);
        highs = 1;
        repeat (10) begin tick(); highs += int'(async_res); end
        check("press_width", highs, 3);
        highs = 0;
        repeat (30) begin tick(); highs += int'(async_res); end
        check("held_no_retrigger", highs, 0);
        button_n = 1'b1;
        repeat (15) tick();

        // Bounce shorter than the debounce window never fires
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            button_n = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            highs += int'(async_res);
        end
        button_n = 1'b1;
        repeat (10) begin tick(); highs += int'(async_res); end
        check("bounce_no_pulse", highs, 0);
        check("bounce_cause", int'(cause), 1);

        // Software request on the same edge the debounced press triggers
        button_n = 1'b0;
        repeat (6) tick();
        check("collide_pre_idle", int'(async_res), 0);
        sw_reboot = 1'b1;
        tick();
        sw_reboot = 1'b0;
        check("collide_async_res", int'(async_res), 1);
        check("collide_cause", int'(cause), 1);
        highs = 1;
        repeat (12) begin tick(); highs += int'(async_res); end
        check("collide_width", highs, 3);
        button_n = 1'b1;
        repeat (15) tick();

        // Asynchronous abort during hold-off
        sw_reboot = 1'b1;
        tick();
        sw_reboot = 1'b0;
        repeat (4) tick();
        check("abort_pre_holdoff", int'(async_res), 0);
        resn = 1'b0;
        #1;
        model_reset();
        check("abort_async_res", int'(async_res), 1);
        check("abort_cause", int'(cause), 0);
        check("abort_busy", int'(busy), 1);
        tick();
        resn = 1'b1;
        repeat (12) tick();

        // Zero hold-off: pulse returns straight to idle
        sw_h = 1'b1;
        tick();
        sw_h = 1'b0;
        check("h0_sw_async_res", int'(async_res_h), 1);
        check("h0_sw_cause", int'(cause_h), 2);
        repeat (2) tick();
        check("h0_sw_still_high", int'(async_res_h), 1);
        tick();
        check("h0_sw_async_res_low", int'(async_res_h), 0);
        check("h0_sw_busy_low", int'(busy_h), 0);

        // Randomized stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) button_n = ~button_n;
            sw_reboot = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                resn = 1'b0;
                #1;
                model_reset();
                check("rand_async_reset", int'(async_res), 1);
            end else begin
                resn = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
